// File: rtl/music_event_receiver.sv
// UART 8N1 receiver for the music-trigger link. Bursts of repeated trigger
// bytes collapse into one event pulse; raw bytes and framing errors are exposed.
module music_event_receiver #(
  parameter int         CLKS_PER_BIT = 564,
  parameter int         GAP_CYCLES   = 1_000_000,
  parameter logic [7:0] TRIGGER_BYTE = 8'hFF
) (
  input  logic       clk_65mhz,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy,
  output logic       event_pulse
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_meta;
  logic          rx_s;
  logic          burst_active;
  logic [TW-1:0] timer;

  // Two-flop synchroniser; idle-high line, so reset to 1.
  always_ff @(posedge clk_65mhz) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
    end
  end

  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk_65mhz) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        // Half a bit in: still low means a real start bit, else a glitch.
        START: begin
          if (cnt == HALF_CNT) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST_CNT) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // Line held low past the stop bit: wait for it to return high.
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Burst tracker: trigger bytes reload the gap timer; only the first one of
  // a burst fires an event. A trigger on the expiry cycle wins as a reload.
  always_ff @(posedge clk_65mhz) begin
    if (!rst_n) begin
      burst_active <= 1'b0;
      timer        <= '0;
      event_pulse  <= 1'b0;
    end else begin
      event_pulse <= 1'b0;
      if (rx_valid && rx_data == TRIGGER_BYTE) begin
        if (!burst_active) begin
          event_pulse <= 1'b1;
        end
        burst_active <= 1'b1;
        timer        <= GAP_LOAD;
      end else if (burst_active) begin
        timer <= timer - TW'(1);
        if (timer <= TW'(1)) begin
          burst_active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_music_event_receiver.sv
// Directed bench for music_event_receiver with CLKS_PER_BIT=8, GAP_CYCLES=200.
module tb_music_event_receiver;

  localparam int C   = 8;
  localparam int GAP = 200;

  logic       clk_65mhz;
  logic       rst_n;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;
  logic       event_pulse;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int valid_cnt = 0;
  int fe_cnt    = 0;
  int evt_cnt   = 0;
  int last_valid_cyc = 0;
  int last_evt_cyc   = 0;
  logic [7:0] last_data = 8'h00;

  music_event_receiver #(
    .CLKS_PER_BIT(C),
    .GAP_CYCLES  (GAP),
    .TRIGGER_BYTE(8'hFF)
  ) dut (
    .clk_65mhz  (clk_65mhz),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy),
    .event_pulse(event_pulse)
  );

  initial clk_65mhz = 1'b0;
  always #5 clk_65mhz = ~clk_65mhz;

  always @(posedge clk_65mhz) cyc <= cyc + 1;

  always @(negedge clk_65mhz) begin
    if (rx_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      last_data = rx_data;
    end
    if (frame_err) fe_cnt++;
    if (event_pulse) begin
      evt_cnt++;
      last_evt_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_65mhz);
      #1;
    end
  endtask

  task automatic hold_bit(input logic v);
    rxd = v;
    step(C);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop_bit);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rxd = i[0];
      step(1);
    end
    n_vec++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %0h expected 0", rx_data); end
    n_vec++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %0b expected 0", rx_valid); end
    n_vec++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %0b expected 0", frame_err); end
    n_vec++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy: got %0b expected 0", rx_busy); end
    n_vec++; if (event_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_event: got %0b expected 0", event_pulse); end
    rxd = 1'b1;
    rst_n = 1'b1;
    step(10);
    n_vec++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %0b expected 0", rx_busy); end
    n_vec++; if (valid_cnt + fe_cnt + evt_cnt !== 0) begin n_fail++; $display("FAIL post_reset_pulses: got %0d expected 0", valid_cnt + fe_cnt + evt_cnt); end
    n_vec++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL post_reset_rx_data: got %0h expected 0", rx_data); end
  endtask

  task automatic test_single_byte;
    int v0, f0, e0, t0, lat;
    v0 = valid_cnt; f0 = fe_cnt; e0 = evt_cnt;
    t0 = cyc;
    send_frame(8'h5A, 1'b1);
    step(4);
    lat = last_valid_cyc - t0;
    n_vec++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL single_valid_count: got %0d expected 1", valid_cnt - v0); end
    n_vec++; if (last_data !== 8'h5A) begin n_fail++; $display("FAIL single_data: got %0h expected 5a", last_data); end
    n_vec++; if (lat < 74 || lat > 82) begin n_fail++; $display("FAIL single_latency: got %0d expected 74..82", lat); end
    n_vec++; if (fe_cnt - f0 !== 0) begin n_fail++; $display("FAIL single_frame_err: got %0d expected 0", fe_cnt - f0); end
    n_vec++; if (evt_cnt - e0 !== 0) begin n_fail++; $display("FAIL single_event: got %0d expected 0", evt_cnt - e0); end
  endtask

  task automatic test_back_to_back;
    int v0, e0, v1;
    v0 = valid_cnt; e0 = evt_cnt;
    send_frame(8'hFF, 1'b1);
    v1 = last_valid_cyc;
    send_frame(8'hFF, 1'b1);
    send_frame(8'hFF, 1'b1);
    step(4);
    n_vec++; if (valid_cnt - v0 !== 3) begin n_fail++; $display("FAIL b2b_valid_count: got %0d expected 3", valid_cnt - v0); end
    n_vec++; if (last_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_data: got %0h expected ff", last_data); end
    n_vec++; if (evt_cnt - e0 !== 1) begin n_fail++; $display("FAIL b2b_event_count: got %0d expected 1", evt_cnt - e0); end
    n_vec++; if (last_evt_cyc !== v1 + 1) begin n_fail++; $display("FAIL b2b_event_latency: got %0d expected %0d", last_evt_cyc, v1 + 1); end
    rxd = 1'b1;
    step(250);
    send_frame(8'hFF, 1'b1);
    step(4);
    n_vec++; if (evt_cnt - e0 !== 2) begin n_fail++; $display("FAIL gap_new_event: got %0d expected 2", evt_cnt - e0); end
    n_vec++; if (last_evt_cyc !== last_valid_cyc + 1) begin n_fail++; $display("FAIL gap_event_latency: got %0d expected %0d", last_evt_cyc, last_valid_cyc + 1); end
  endtask

  task automatic test_start_glitch;
    int v0, f0;
    v0 = valid_cnt; f0 = fe_cnt;
    rxd = 1'b0;
    step(2);
    rxd = 1'b1;
    step(20);
    n_vec++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d expected 0", valid_cnt - v0); end
    n_vec++; if (fe_cnt - f0 !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_cnt - f0); end
    n_vec++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %0b expected 0", rx_busy); end
  endtask

  task automatic test_frame_error;
    int v0, f0;
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'hA5, 1'b0);
    rxd = 1'b1;
    step(10);
    n_vec++; if (fe_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt - f0); end
    n_vec++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d expected 0", valid_cnt - v0); end
    n_vec++; if (rx_data !== 8'hFF) begin n_fail++; $display("FAIL ferr_data_kept: got %0h expected ff", rx_data); end
    n_vec++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy: got %0b expected 0", rx_busy); end
    send_frame(8'h3C, 1'b1);
    step(4);
    n_vec++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL ferr_next_valid: got %0d expected 1", valid_cnt - v0); end
    n_vec++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL ferr_next_data: got %0h expected 3c", rx_data); end
  endtask

  task automatic test_reset_mid_frame;
    int v0, f0, e0;
    logic [7:0] b;
    b = 8'hFF;
    v0 = valid_cnt; f0 = fe_cnt; e0 = evt_cnt;
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(b[i]);
    rxd = b[4];
    step(3);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    rxd = 1'b1;
    step(100);
    n_vec++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL midrst_valid: got %0d expected 0", valid_cnt - v0); end
    n_vec++; if (evt_cnt - e0 !== 0) begin n_fail++; $display("FAIL midrst_event: got %0d expected 0", evt_cnt - e0); end
    n_vec++; if (fe_cnt - f0 !== 0) begin n_fail++; $display("FAIL midrst_frame_err: got %0d expected 0", fe_cnt - f0); end
    n_vec++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %0h expected 0", rx_data); end
    n_vec++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %0b expected 0", rx_busy); end
    send_frame(8'hFF, 1'b1);
    step(4);
    n_vec++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL midrst_next_valid: got %0d expected 1", valid_cnt - v0); end
    n_vec++; if (rx_data !== 8'hFF) begin n_fail++; $display("FAIL midrst_next_data: got %0h expected ff", rx_data); end
    n_vec++; if (evt_cnt - e0 !== 1) begin n_fail++; $display("FAIL midrst_next_event: got %0d expected 1", evt_cnt - e0); end
  endtask

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    #1;
    test_reset;
    test_single_byte;
    test_back_to_back;
    test_start_glitch;
    test_frame_error;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
